// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered data and
// per-slot ghost blanking. Optional leading-zero suppression: define SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_mask,
  output logic        ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [1:0]    idx;
  logic [15:0]   pending, shadow;
  logic [3:0]    pending_dp, shadow_dp;
  logic          pending_v;
  logic          slot_end, frame_end, commit;
  logic [3:0]    nib;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign slot_end  = en && (count == CW'(DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);
  assign commit    = frame_end && pending_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      idx   <= 2'd0;
    end else if (en) begin
      if (slot_end) begin
        count <= '0;
        idx   <= idx + 2'd1;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BLANK;
    else        state <= state_nxt;
  end

  // The FSM mirrors the count window, so it only moves while the prescaler moves.
  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:   if (en && count == CW'(BLANK_CYC - 1)) state_nxt = DRIVE;
      DRIVE:   if (slot_end) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_v <= 1'b0;
    else if (load) pending_v <= 1'b1;
    else if (commit) pending_v <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pending    <= data;
      pending_dp <= dp_mask;
    end
  end

  // Commit reads the old pending value, so a load on the boundary waits one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= 16'h0000;
      shadow_dp <= 4'h0;
    end else if (commit) begin
      shadow    <= pending;
      shadow_dp <= pending_dp;
    end
  end

  assign nib = shadow[{idx, 2'b00} +: 4];

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    if (en && state == DRIVE) begin
      an_nxt      = 4'b1111;
      an_nxt[idx] = 1'b0;
      seg_nxt     = seg_decode(nib);
      dp_nxt      = ~shadow_dp[idx];
`ifdef SEG_LZ_BLANK_EN
      if ((idx == 2'd1 && shadow[15:4]  == 12'h000) ||
          (idx == 2'd2 && shadow[15:8]  == 8'h00)   ||
          (idx == 2'd3 && shadow[15:12] == 4'h0)) begin
        an_nxt  = 4'b1111;
        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
      end
`endif
    end
  end

  // Output register stage: pins lag internal state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
      ack <= 1'b0;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
      ack <= commit;
    end
  end

endmodule
